// File: rtl/mips_pkg.sv
// Shared constants, state encodings and control bundle for the
// multi-cycle MIPS controller and its ALU decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10,
    AOP_OR    = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

  // Moore outputs of a state; alu is the decoded ALU function
  // for the instruction currently held in IR.
  function automatic ctrl_t ctrl_of(
    input state_e     s,
    input logic [2:0] alu,
    input logic       beq,
    input logic       bne,
    input logic       ori
  );
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_ctrl  = ALU_ADD;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = alu;
      end
      S_ALUWB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_ctrl   = ALU_SUB;
        c.pc_src     = 2'b01;
        c.branch     = beq;
        c.branch_ne  = bne;
        c.instr_done = 1'b1;
      end
      S_IMMEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_ctrl  = alu;
        c.imm_zext  = ori;
      end
      S_IMMWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = 2'b10;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_mips_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// mux selects, strobes and status out. master = controller side.
interface multi_cycle_mips_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             pc_en;
  logic             iord;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             imm_zext;
  logic [2:0]       alu_ctrl;
  logic [1:0]       pc_src;
  logic             instr_done;
  logic             illegal;
  logic [3:0]       state_dbg;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_write, ir_write,
    output reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, imm_zext,
    output alu_ctrl, pc_src, instr_done,
    output illegal, state_dbg, retired
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_write, ir_write,
    input  reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, imm_zext,
    input  alu_ctrl, pc_src, instr_done,
    input  illegal, state_dbg, retired
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// Maps alu_op (00 add, 01 sub, 10 funct, 11 or) plus funct to alu_ctrl;
// funct_valid_o drops for an unsupported R-type funct.
import mips_pkg::*;

module mips_alu_decoder (
  input  alu_op_e    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       funct_valid_o
);

  always_comb begin
    alu_ctrl_o    = ALU_ADD;
    funct_valid_o = 1'b1;
    case (alu_op_i)
      AOP_ADD: alu_ctrl_o = ALU_ADD;
      AOP_SUB: alu_ctrl_o = ALU_SUB;
      AOP_OR:  alu_ctrl_o = ALU_OR;
      AOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: funct_valid_o = 1'b0;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_mips_ctrl.sv
// Multi-cycle MIPS main control FSM with registered Moore outputs,
// gated PC enable, illegal-op detect and retired-instruction counter.
import mips_pkg::*;

module multi_cycle_mips_ctrl #(
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   reset,
  multi_cycle_mips_ctrl_if.master bus
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] retired_q;

  logic    is_r, is_lw, is_sw, is_beq, is_bne;
  logic    is_addi, is_ori, is_j;
  logic    funct_ok, dec_legal;
  alu_op_e alu_op;
  logic [2:0] alu_dec;

  assign is_r    = bus.opcode == OP_RTYPE;
  assign is_lw   = bus.opcode == OP_LW;
  assign is_sw   = bus.opcode == OP_SW;
  assign is_beq  = bus.opcode == OP_BEQ;
  assign is_bne  = bus.opcode == OP_BNE;
  assign is_addi = bus.opcode == OP_ADDI;
  assign is_ori  = bus.opcode == OP_ORI;
  assign is_j    = bus.opcode == OP_J;

  // ALU op depends only on the opcode held in IR, so the
  // funct check is available while still in DECODE.
  always_comb begin
    alu_op = AOP_ADD;
    unique case (1'b1)
      is_r:            alu_op = AOP_FUNCT;
      is_beq | is_bne: alu_op = AOP_SUB;
      is_ori:          alu_op = AOP_OR;
      default:         alu_op = AOP_ADD;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct_i       (bus.funct),
    .alu_ctrl_o    (alu_dec),
    .funct_valid_o (funct_ok)
  );

  assign dec_legal = is_lw | is_sw | (is_r & funct_ok)
                   | is_beq | is_bne | is_addi | is_ori | is_j;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw | is_sw:      state_d = S_MEMADR;
          is_r & funct_ok:    state_d = S_EXEC;
          is_beq | is_bne:    state_d = S_BRANCH;
          is_addi | is_ori:   state_d = S_IMMEX;
          is_j:               state_d = S_JUMP;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMWB, S_MEMWR, S_ALUWB,
      S_BRANCH, S_IMMWB, S_JUMP:
                state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
    ctrl_d = ctrl_of(state_d, alu_dec, is_beq, is_bne, is_ori);
  end

  // Outputs are registered alongside the state, so an async
  // reset clears every strobe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (ctrl_q.instr_done)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.pc_en = ctrl_q.pc_write
                   | (ctrl_q.branch & bus.zero)
                   | (ctrl_q.branch_ne & ~bus.zero);

  assign bus.illegal    = (state_q == S_DECODE) & ~dec_legal;
  assign bus.iord       = ctrl_q.iord;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.ir_write   = ctrl_q.ir_write;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.imm_zext   = ctrl_q.imm_zext;
  assign bus.alu_ctrl   = ctrl_q.alu_ctrl;
  assign bus.pc_src     = ctrl_q.pc_src;
  assign bus.instr_done = ctrl_q.instr_done;
  assign bus.state_dbg  = state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multi_cycle_mips_ctrl.sv
// Directed bench for multi_cycle_mips_ctrl: reset, per-instruction
// state walks, branch gating, illegal decode and async reset.
module tb_multi_cycle_mips_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   cyc0;

  logic [4:0] rw_m, mtr_m, mw_m, zx_m, pe_m, ill_m, dn_m;
  logic [2:0] alu_seen;

  multi_cycle_mips_ctrl_if #(.CNT_W(32)) bus ();

  multi_cycle_mips_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Starts sampled in FETCH; walks n states, checking the state
  // sequence (nibbles MSB first) and recording strobes per cycle.
  task automatic instr(input string tag,
                       input logic [5:0] op,
                       input logic [5:0] fn,
                       input logic [19:0] seq,
                       input int n);
    bus.opcode = op;
    bus.funct  = fn;
    rw_m = '0; mtr_m = '0; mw_m = '0; zx_m = '0;
    pe_m = '0; ill_m = '0; dn_m = '0;
    alu_seen = 3'bxxx;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s st%0d", tag, i),
          32'(bus.state_dbg), 32'(seq[19-4*i -: 4]));
      rw_m[i]  = bus.reg_write;
      mtr_m[i] = bus.mem_to_reg;
      mw_m[i]  = bus.mem_write;
      zx_m[i]  = bus.imm_zext;
      pe_m[i]  = bus.pc_en;
      ill_m[i] = bus.illegal;
      dn_m[i]  = bus.instr_done;
      if (bus.state_dbg == 4'd7) alu_seen = bus.alu_ctrl;
      tick();
    end
  endtask

  function automatic logic [31:0] outs_or();
    return 32'({bus.pc_en, bus.iord, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.imm_zext, bus.alu_ctrl, bus.pc_src,
                bus.instr_done, bus.illegal});
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b0;
    bus.opcode = 6'b0;
    bus.funct  = 6'b0;
    bus.zero   = 1'b0;

    repeat (3) tick();
    chk("rst outs", outs_or(), 32'h0);
    chk("rst state", 32'(bus.state_dbg), 32'd0);
    chk("rst retired", bus.retired, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle state", 32'(bus.state_dbg), 32'd0);
    chk("idle outs", outs_or(), 32'h0);
    tick();
    chk("first fetch", 32'(bus.state_dbg), 32'd1);
    chk("fetch pc_en", 32'(bus.pc_en), 32'd1);
    chk("fetch ir_write", 32'(bus.ir_write), 32'd1);
    chk("fetch alu_src_b", 32'(bus.alu_src_b), 32'd1);
    chk("retired 0", bus.retired, 32'd0);

    // lw: 5 cycles
    instr("lw", 6'b100011, 6'b0, 20'h12345, 5);
    chk("lw reg_write", 32'(rw_m), 32'b10000);
    chk("lw mem_to_reg", 32'(mtr_m), 32'b10000);
    chk("lw done", 32'(dn_m), 32'b10000);
    chk("lw retired", bus.retired, 32'd1);

    // beq taken / not taken
    bus.zero = 1'b1;
    instr("beq t", 6'b000100, 6'b0, 20'h12900, 3);
    chk("beq t pc_en", 32'(pe_m), 32'b101);
    bus.zero = 1'b0;
    instr("beq n", 6'b000100, 6'b0, 20'h12900, 3);
    chk("beq n pc_en", 32'(pe_m), 32'b001);
    chk("beq retired", bus.retired, 32'd3);

    // slt, then unsupported funct
    instr("slt", 6'b000000, 6'b101010, 20'h12780, 4);
    chk("slt alu_ctrl", 32'(alu_seen), 32'b111);
    chk("slt reg_write", 32'(rw_m), 32'b1000);
    instr("badfn", 6'b000000, 6'b000000, 20'h12000, 2);
    chk("badfn illegal", 32'(ill_m), 32'b10);
    chk("badfn reg_write", 32'(rw_m), 32'b00);
    chk("badfn next", 32'(bus.state_dbg), 32'd1);
    chk("badfn retired", bus.retired, 32'd4);
    chk("illegal clr", 32'(bus.illegal), 32'd0);

    // add, sw, ori, j, bne: 18 cycles
    cyc0 = cyc;
    instr("add", 6'b000000, 6'b100000, 20'h12780, 4);
    chk("add zext", 32'(zx_m), 32'b0);
    instr("sw", 6'b101011, 6'b0, 20'h12360, 4);
    chk("sw mem_write", 32'(mw_m), 32'b1000);
    chk("sw reg_write", 32'(rw_m), 32'b0000);
    instr("ori", 6'b001101, 6'b0, 20'h12ab0, 4);
    chk("ori zext", 32'(zx_m), 32'b0100);
    chk("ori reg_write", 32'(rw_m), 32'b1000);
    instr("j", 6'b000010, 6'b0, 20'h12c00, 3);
    chk("j pc_en", 32'(pe_m), 32'b101);
    chk("j zext", 32'(zx_m), 32'b0);
    bus.zero = 1'b0;
    instr("bne", 6'b000101, 6'b0, 20'h12900, 3);
    chk("bne pc_en", 32'(pe_m), 32'b101);
    chk("seq cycles", 32'(cyc - cyc0), 32'd18);
    chk("seq retired", bus.retired, 32'd9);

    // async reset in MEMWR
    bus.opcode = 6'b101011;
    tick();
    tick();
    tick();
    chk("memwr state", 32'(bus.state_dbg), 32'd6);
    chk("memwr strobe", 32'(bus.mem_write), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst mem_write", 32'(bus.mem_write), 32'd0);
    chk("arst state", 32'(bus.state_dbg), 32'd0);
    chk("arst retired", bus.retired, 32'd0);
    chk("arst outs", outs_or(), 32'h0);
    tick();
    chk("arst hold", bus.retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    instr("j2", 6'b000010, 6'b0, 20'h12c00, 3);
    chk("post rst retired", bus.retired, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_mips_ctrl.md
Name: multi_cycle_mips_ctrl

Overview:
Main control FSM for the multi-cycle MIPS core, the successor to single_cycle_mips. It sequences the shared datapath (one memory for instructions and data, one ALU) over 3-5 cycles per instruction. It drives every mux select and write enable, and it also produces the gated PC enable. It counts retired instructions so benches can measure CPI.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
pc_en  out  1  PC register load enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  write register select: 0 = rt, 1 = rd
mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
imm_zext  out  1  immediate is zero-extended (ori)
alu_ctrl  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal  out  1  one-cycle pulse when an unsupported opcode or funct is decoded
state_dbg  out  4  current state encoding
retired  out  CNT_W  count of instr_done pulses

Behaviour:
- Reset is asynchronous, active-low.
  - Reset sets the state to IDLE and clears retired.
  - All outputs are 0 in IDLE, including pc_en and mem_write.
- The FSM is Moore. Exceptions:
  - pc_en = pc_write | (branch & zero) | (branch_ne & ~zero), combinational from the zero input.
  - illegal is decoded in DECODE from opcode and funct.
- States and transitions (state_dbg encoding in brackets):
  - IDLE [0] -> FETCH.
  - FETCH [1]: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00, pc_write=1. -> DECODE.
  - DECODE [2]: alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target into ALUOut). Next state by opcode:
    - lw 100011 or sw 101011 -> MEMADR.
    - R-type 000000 -> EXEC.
    - beq 000100 or bne 000101 -> BRANCH.
    - addi 001000 or ori 001101 -> IMMEX.
    - j 000010 -> JUMP.
    - Any other opcode -> FETCH, with illegal=1 and no register or memory write.
  - MEMADR [3]: alu_src_a=1, alu_src_b=10, add. -> MEMRD for lw, MEMWR for sw.
  - MEMRD [4]: iord=1. -> MEMWB.
  - MEMWB [5]: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done. -> FETCH.
  - MEMWR [6]: iord=1, mem_write=1, instr_done. -> FETCH.
  - EXEC [7]: alu_src_a=1, alu_src_b=00, alu_ctrl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. -> ALUWB.
    - An unsupported funct is flagged in DECODE (illegal=1); the FSM then goes from DECODE to FETCH, not EXEC.
  - ALUWB [8]: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done. -> FETCH.
  - BRANCH [9]: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch (beq) or branch_ne (bne), instr_done. -> FETCH.
  - IMMEX [10]: alu_src_a=1, alu_src_b=10. addi uses add with imm_zext=0; ori uses or with imm_zext=1. -> IMMWB.
  - IMMWB [11]: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done. -> FETCH.
  - JUMP [12]: pc_src=10, pc_write=1, instr_done. -> FETCH.
- Latency in cycles: lw 5; sw, R-type, addi, ori 4; beq, bne, j 3; illegal 2 (not retired).
- retired increments on every instr_done and wraps from 2^CNT_W-1 to 0.
- Any output not listed for a state is 0.
- Reset asserted mid-instruction:
  - The FSM returns to IDLE immediately, without waiting for a clock edge.
  - Any write strobe drops at the same time.
  - A partial instruction is never retired.
- Unused state encodings 13-15 -> IDLE.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J
  - funct constants
  - ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - state encodings
- One sub-module, mips_alu_decoder: combinational; maps a 2-bit alu_op (00 add, 01 sub, 10 funct, 11 or) plus funct to alu_ctrl and funct_valid.

Test Plan:
- Hold reset=0 for 3 cycles, then release → all outputs 0 and state_dbg=0 during reset; state_dbg reaches 1 on the first edge after release; retired=0.
- lw (opcode 100011) → states 1,2,3,4,5; reg_write=1 and mem_to_reg=1 only in state 5; retired=1 after 5 cycles.
- beq with zero=1, then beq with zero=0 → pc_en=1 in state 9 for the first, pc_en=0 for the second; each takes 3 cycles.
- R-type with funct 101010 → alu_ctrl=111 in state 7. Then funct 000000 → illegal pulses in state 2, next state 1, reg_write never asserted, retired unchanged.
- Sequence add, sw, ori, j, bne → total 4+4+4+3+3 = 18 cycles and retired=5; imm_zext=1 only in ori's IMMEX.
- Assert reset low during MEMWR, asynchronously mid-cycle → mem_write falls within the same cycle; state_dbg=0; retired cleared.
